// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM fetch unit.
// Display support is compiled in only when ROM_FETCH_SEG_EN is defined.
package rom_fetch_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Active-low gfedcba patterns, digit 0 in the least significant slot.
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return SEG_LUT[nib*7 +: 7];
  endfunction

endpackage

// File: rtl/rom_fetch_fifo.sv
// rf_fifo2: two-entry synchronous FIFO with flush and occupancy count.
// Entry 0 is always the head, so the output is a plain register.
module rf_fifo2
  import rom_fetch_pkg::*;
#(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic         push_ok;
  logic         pop_ok;

  // Qualify requests against current occupancy.
  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    push_ok = push && ((count != 2'(FIFO_DEPTH)) || pop_ok);
    dout    = e0;
  end

  // Storage and count update; flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rom_fetch.sv
// rom_fetch: sequential ROM read initiator with a valid/ready output stream,
// credit-based back-pressure and branch redirect.
// Optional hex display of the last accepted word: define ROM_FETCH_SEG_EN.
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef ROM_FETCH_SEG_EN
  ,
  parameter int SEG_DIV = 17
`endif
)(
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              busy,
  output logic              done
`ifdef ROM_FETCH_SEG_EN
  ,
  output logic [6:0]        segs,
  output logic [7:0]        ans
`endif
);

  localparam int EW = ADDR_W + DATA_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] end_addr, end_nxt;
  logic [ADDR_W-1:0] resp_addr;
  logic              resp_v;
  logic              done_nxt;
  logic              pop;
  logic              redir_take;
  logic              fifo_pop;
  logic              push;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic [2:0]        credit;
  logic [EW-1:0]     head;
  logic [EW-1:0]     resp_word;

  // An empty FIFO lets the arriving ROM word fall straight through to the
  // consumer; once a word is held it is served from the registered head.
  always_comb begin
    resp_word  = {resp_addr, douta};
    inst_valid = (count != 2'd0) || resp_v;
    if (count != 2'd0)  {inst_addr, inst_data} = head;
    else if (resp_v)    {inst_addr, inst_data} = resp_word;
    else                {inst_addr, inst_data} = '0;
    pop        = inst_valid && inst_ready;
    fifo_pop   = pop && (count != 2'd0);
    push       = resp_v && !(pop && (count == 2'd0));
    count_nxt  = count - 2'(fifo_pop) + 2'(push);
    redir_take = redirect && (state != IDLE);
    credit     = 3'(FIFO_DEPTH) - 3'(count) - 3'(resp_v) + 3'(pop);
    ena        = (state == FETCH) && (credit != 3'd0);
    addra      = pc;
    busy       = (state != IDLE);
  end

  rf_fifo2 #(
    .W (EW)
  ) u_fifo (
    .clk   (clka),
    .rst_n (rst),
    .push  (push),
    .pop   (fifo_pop),
    .flush (redir_take),
    .din   (resp_word),
    .dout  (head),
    .count (count)
  );

  // Next-state logic; redirect overrides every other transition.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    end_nxt   = end_addr;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          pc_nxt    = base_addr;
          end_nxt   = last_addr;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (ena) begin
          if (pc == end_addr) state_nxt = DRAIN;
          else                pc_nxt    = pc + 1'b1;
        end
      end
      DRAIN: begin
        // No issues happen here, so only the FIFO must empty out.
        if (count_nxt == 2'd0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redir_take) begin
      pc_nxt    = redirect_addr;
      state_nxt = FETCH;
      done_nxt  = 1'b0;
    end
  end

  // State, address and response-tracking registers.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= '0;
      end_addr  <= '0;
      done      <= 1'b0;
      resp_v    <= 1'b0;
      resp_addr <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      end_addr <= end_nxt;
      done     <= done_nxt;
      resp_v   <= ena && !redir_take;
      if (ena) resp_addr <= pc;
    end
  end

`ifdef ROM_FETCH_SEG_EN
  logic [SEG_DIV-1:0] scan;
  logic [31:0]        disp;
  logic [2:0]         dig;

  always_comb dig = scan[SEG_DIV-1 -: 3];

  // Free-running scan over 8 digits of the last accepted word.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      scan <= '0;
      disp <= '0;
      segs <= '1;
      ans  <= '1;
    end else begin
      scan <= scan + 1'b1;
      if (pop) disp <= inst_data[31:0];
      segs <= hex7(disp[{dig, 2'b00} +: 4]);
      ans  <= ~(8'b1 << dig);
    end
  end
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// Self-checking bench for rom_fetch with a synchronous ROM model and a
// queue-based reference of the expected word stream.
module tb_rom_fetch;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  logic          clka = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          redirect = 1'b0;
  logic          inst_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [AW-1:0] redirect_addr = '0;
  logic          ena;
  logic [AW-1:0] addra;
  logic [DW-1:0] douta = '0;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_addr;
  logic          busy;
  logic          done;
`ifdef ROM_FETCH_SEG_EN
  logic [6:0]    segs;
  logic [7:0]    ans;
`endif

  logic [DW-1:0] rom [1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops, done_cnt, done_cyc, first_pop_cyc, last_pop_cyc, first_ena_cyc;
  int t0, p;
  word_t exp_q[$];
  logic [AW-1:0] ena_log[$];
  logic  held = 1'b0;
  word_t held_w;

  rom_fetch #(
    .ADDR_W (AW),
    .DATA_W (DW)
`ifdef ROM_FETCH_SEG_EN
    ,
    .SEG_DIV (4)
`endif
  ) dut (
    .clka          (clka),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .last_addr     (last_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .ena           (ena),
    .addra         (addra),
    .douta         (douta),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_addr     (inst_addr),
    .busy          (busy),
    .done          (done)
`ifdef ROM_FETCH_SEG_EN
    ,
    .segs          (segs),
    .ans           (ans)
`endif
  );

  always #5 clka = ~clka;

  always @(posedge clka) if (ena) douta <= rom[addra];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected stream: every address from 'from' up to 'to' inclusive, mod 1024.
  task automatic build(input logic [AW-1:0] from, input logic [AW-1:0] to);
    logic [AW-1:0] a;
    a = from;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back({a, rom[a]});
      if (a == to) break;
      a = a + 1'b1;
    end
  endtask

  task automatic clear_stats();
    ena_log.delete();
    pops = 0; done_cnt = 0; done_cyc = -1;
    first_pop_cyc = -1; last_pop_cyc = -1; first_ena_cyc = -1;
  endtask

  task automatic monitor();
    word_t w;
    if (ena) begin
      ena_log.push_back(addra);
      if (first_ena_cyc < 0) first_ena_cyc = cyc;
    end
    if (held && rst) begin
      chk("hold_valid", inst_valid, 1);
      chk("hold_word", {inst_addr, inst_data}, held_w);
    end
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word_queue_size", exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        chk("word", {inst_addr, inst_data}, w);
      end
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      chk("done_words_left", exp_q.size(), 0);
      chk("busy_low_at_done", busy, 0);
    end
    held   = inst_valid && !inst_ready && !redirect && rst;
    held_w = {inst_addr, inst_data};
  endtask

  task automatic sample();
    @(negedge clka);
    monitor();
  endtask

  task automatic advance();
    @(posedge clka);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] l);
    base_addr = b;
    last_addr = l;
    build(b, l);
    clear_stats();
    t0 = cyc;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int maxc);
    int n;
    n = 0;
    while (done_cnt == 0 && n < maxc) begin
      cycle();
      n++;
    end
    chk("run_completed", done_cnt != 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ena"}, ena, 0);
    chk({tag, "_addra"}, addra, 0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_inst_data"}, inst_data, 0);
    chk({tag, "_inst_addr"}, inst_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef ROM_FETCH_SEG_EN
    chk({tag, "_segs"}, segs, 7'h7F);
    chk({tag, "_ans"}, ans, 8'hFF);
`endif
  endtask

`ifdef ROM_FETCH_SEG_EN
  function automatic logic [6:0] tb_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction
`endif

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'(i) * 32'd4;
    clear_stats();

    // Reset state.
    #1;
    sample();
    chk_reset_outputs("reset");
    advance();
    cycle();
    rst = 1'b1;
    advance();

    // Four-word run, ROM word = addr*4, ready high.
    inst_ready = 1'b1;
    start_run(10'h000, 10'h003);
    run_until_done(20);
    chk("A_first_ena_cyc", first_ena_cyc, t0 + 1);
    chk("A_first_ena_addr", ena_log.size() > 0 ? ena_log[0] : 10'h3FF, 10'h000);
    chk("A_ena_count", ena_log.size(), 4);
    chk("A_first_valid_cyc", first_pop_cyc, t0 + 2);
    chk("A_last_valid_cyc", last_pop_cyc, t0 + 5);
    chk("A_pops", pops, 4);
    chk("A_done_cyc", done_cyc, t0 + 6);
    cycle();
    chk("A_single_done", done_cnt, 1);

    for (int i = 0; i < 1024; i++) rom[i] = $urandom;

    // Wrapping run 0x3FE..0x001.
    start_run(10'h3FE, 10'h001);
    run_until_done(20);
    chk("B_ena_count", ena_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("B_addra_seq", ena_log.size() > i ? ena_log[i] : 10'hx, 10'(10'h3FE + i));
    chk("B_pops", pops, 4);

    // Back-pressure: consumer stalls, then random ready.
    inst_ready = 1'b0;
    start_run(10'h010, 10'h01F);
    for (int i = 0; i < 12; i++) cycle();
    chk("C_ena_during_stall", ena_log.size(), 2);
    chk("C_valid_during_stall", inst_valid, 1);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("C_run_completed", done_cnt, 1);
    chk("C_pops", pops, 16);
    inst_ready = 1'b1;

    // Redirect while a word is buffered and another is in flight.
    inst_ready = 1'b0;
    start_run(10'h0F0, 10'h10F);
    cycle();
    redirect = 1'b1;
    redirect_addr = 10'h100;
    cycle();
    redirect = 1'b0;
    build(10'h100, 10'h10F);
    inst_ready = 1'b1;
    sample();
    chk("D_valid_after_redirect", inst_valid, 0);
    chk("D_ena_after_redirect", ena, 1);
    chk("D_addra_after_redirect", addra, 10'h100);
    advance();
    sample();
    chk("D_new_valid", inst_valid, 1);
    chk("D_new_addr", inst_addr, 10'h100);
    advance();
    run_until_done(40);

    // Redirect in the same cycle as a pop.
    start_run(10'h200, 10'h20F);
    for (int i = 0; i < 4; i++) cycle();
    redirect = 1'b1;
    redirect_addr = 10'h20C;
    cycle();
    redirect = 1'b0;
    p = pops;
    build(10'h20C, 10'h20F);
    run_until_done(40);
    chk("E_pops_after_redirect", pops, p + 4);

    // start and redirect together in IDLE: start wins.
    base_addr = 10'h050;
    last_addr = 10'h052;
    build(10'h050, 10'h052);
    clear_stats();
    start = 1'b1;
    redirect = 1'b1;
    redirect_addr = 10'h300;
    cycle();
    start = 1'b0;
    redirect = 1'b0;
    run_until_done(20);
    chk("F_first_addr", ena_log.size() > 0 ? ena_log[0] : 10'h3FF, 10'h050);
    chk("F_pops", pops, 3);

    // Redirect alone in IDLE is ignored.
    redirect = 1'b1;
    redirect_addr = 10'h123;
    cycle();
    redirect = 1'b0;
    sample();
    chk("G_busy", busy, 0);
    chk("G_ena", ena, 0);
    advance();

    // Asynchronous reset mid-run, then a clean restart.
    start_run(10'h080, 10'h08F);
    for (int i = 0; i < 20 && pops < 5; i++) cycle();
    chk("H_pops_before_reset", pops, 5);
    rst = 1'b0;
    sample();
    chk_reset_outputs("H_reset");
    advance();
    cycle();
    rst = 1'b1;
    chk("H_no_done", done_cnt, 0);
    advance();
    start_run(10'h080, 10'h08F);
    run_until_done(40);
    chk("H_restart_addr", ena_log.size() > 0 ? ena_log[0] : 10'h3FF, 10'h080);
    chk("H_restart_pops", pops, 16);

`ifdef ROM_FETCH_SEG_EN
    begin
      logic [7:0]  seen;
      logic [31:0] word;
      word = 32'h1234ABCD;
      rom[10'h3A0] = word;
      start_run(10'h3A0, 10'h3A0);
      run_until_done(20);
      seen = '0;
      for (int c = 0; c < 40; c++) begin
        sample();
        for (int d = 0; d < 8; d++) begin
          if (ans == ~(8'b1 << d)) begin
            seen[d] = 1'b1;
            chk("S_segs", segs, tb_hex(word[d*4 +: 4]));
          end
        end
        advance();
      end
      chk("S_digits_seen", seen, 8'hFF);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
